pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline control unit: the consuming end of the ID/EX register outputs (EX_mem_read, EX_rt) and the source of every enable/flush the pipeline registers obey. It detects load-use hazards, flushes wrong-path instructions on a branch resolved in MEM, runs the HALT drain sequence, and provides debug single-step. It sits beside the IF/ID, ID/EX and EX/MEM registers and the PC register; each of those gains an enable and/or flush input driven from here.

## Interface
- NB_REG, 5, register-address width
- NB_CNT, 32, width of the performance counters
- DRAIN_CYCLES, 3, cycles needed after HALT leaves ID for the instructions ahead of it to retire (EX, MEM, WB)

- i_clock  in  1  system clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_ID_rs  in  NB_REG  rs of the instruction in ID
- i_ID_rt  in  NB_REG  rt of the instruction in ID
- i_ID_uses_rt  in  1  ID instruction reads rt as a source
- i_ID_halt  in  1  ID instruction is HALT
- i_EX_mem_read  in  1  EX instruction is a load (ID/EX register output)
- i_EX_rt  in  NB_REG  load destination in EX (ID/EX register output)
- i_MEM_branch_taken  in  1  branch resolved taken in MEM
- i_step_mode  in  1  debug single-step mode request (level)
- i_step  in  1  advance one cycle (one-cycle pulse)
- o_pipe_enable  out  1  global clock-enable for all pipeline registers and the PC
- o_pc_write  out  1  PC register loads its next value
- o_IF_ID_write  out  1  IF/ID register loads
- o_IF_ID_flush  out  1  IF/ID register loads a NOP
- o_ID_EX_flush  out  1  ID/EX register loads zero control bits (bubble)
- o_EX_MEM_flush  out  1  EX/MEM register loads zero control bits
- o_halted  out  1  processor halted
- o_cycle_count  out  NB_CNT  cycles with o_pipe_enable=1 since reset
- o_stall_count  out  NB_CNT  load-use stall cycles, saturating at all-ones

## Operation
- States: RUN, STEP_WAIT, STEP_EXEC, HALT_DRAIN, HALTED.
- load_use = i_EX_mem_read & (i_EX_rt != 0) & ((i_EX_rt == i_ID_rs) | (i_ID_uses_rt & i_EX_rt == i_ID_rt)).
- Active states (RUN, STEP_EXEC): o_pipe_enable=1; priority branch > load_use > halt > normal.
  - Branch: all three flushes=1, o_pc_write=1, o_IF_ID_write=1; i_ID_halt ignored (wrong path).
  - Load-use: o_pc_write=0, o_IF_ID_write=0, o_ID_EX_flush=1; o_stall_count +1.
  - Halt (no branch, no load_use): o_pc_write=0, o_IF_ID_write=0, o_ID_EX_flush=1; next state HALT_DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - Normal: o_pc_write=1, o_IF_ID_write=1, flushes=0.
- RUN -> STEP_WAIT when i_step_mode=1 and no halt taken this cycle (current cycle still executes).
- STEP_WAIT: o_pipe_enable=0, all other controls 0. i_step=1 -> STEP_EXEC; i_step_mode=0 -> RUN (i_step ignored if both).
- STEP_EXEC: exactly one active cycle; then STEP_WAIT if i_step_mode=1, else RUN; halt -> HALT_DRAIN.
- HALT_DRAIN: o_pipe_enable=1, o_pc_write=0, o_IF_ID_write=0, o_ID_EX_flush=1; counter decrements; at 0 -> HALTED. i_MEM_branch_taken here: older branch makes HALT wrong-path -> all flushes=1, o_pc_write=1, o_IF_ID_write=1, next state RUN. i_step_mode ignored.
- HALTED: o_pipe_enable=0, o_halted=1; exits only through reset.
- o_cycle_count wraps; o_stall_count saturates.

## Timing
- All control outputs are Mealy: combinational from state and same-cycle inputs, sampled by pipeline registers at the next i_clock edge. State and counters registered.
- Load-use stall: exactly 1 cycle per hazard (the bubble clears load_use next cycle).
- HALT in ID at cycle t: HALT_DRAIN during t+1..t+DRAIN_CYCLES, o_halted=1 from t+DRAIN_CYCLES+1.
- Reset (i_reset_n=0 at an edge): state RUN, counters 0. While i_reset_n=0 outputs forced: o_pipe_enable=1, all flushes=1, o_pc_write=0, o_IF_ID_write=0, o_halted=0. Reset mid-drain or mid-step returns to RUN with no residue.

## Structure
- Shared package: state encoding, DRAIN_CYCLES default, NB_REG.
- Sub-module load_use_detector (combinational comparator, reusable in a forwarding unit); FSM, counters and output decode in the top.

## Test plan
- lw $5 in EX, ID add uses rs=5 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_count 0->1; next cycle normal.
- lw $0 in EX, ID rs=0 -> no stall; lw $5 with ID rt=5, i_ID_uses_rt=0 -> no stall.
- Branch taken in MEM coincident with load_use and i_ID_halt -> all flushes=1, pc_write=1, stall_count unchanged, state stays RUN.
- i_ID_halt in RUN -> 3 drain cycles with pc_write=0, then o_halted=1, o_pipe_enable=0; branch on drain cycle 2 -> RUN, no halt.
- i_step_mode=1, three i_step pulses 5 cycles apart -> o_pipe_enable high exactly 3 cycles after the first, cycle_count +3 during that window.
- i_reset_n=0 during HALT_DRAIN -> next cycle RUN, counters 0, o_halted=0, flushes=1 while held.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// Holds the FSM encoding and the bundle of control outputs.
package pipeline_hazard_ctrl_pkg;

  localparam int NB_REG       = 5;
  localparam int NB_CNT       = 32;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_HALT_DRAIN,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic pipe_enable;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '{default: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{
    pipe_enable: 1'b1, pc_write: 1'b1, if_id_write: 1'b1,
    default: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{
    pipe_enable: 1'b1, id_ex_flush: 1'b1,
    default: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{
    pipe_enable: 1'b1, pc_write: 1'b1, if_id_write: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
    default: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{
    pipe_enable: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
    default: 1'b0};
  localparam ctrl_t CTRL_HALTED = '{
    halted: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline registers and the hazard controller.
// master = pipeline side, slave = controller side.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [NB_REG-1:0] i_ID_rs;
  logic [NB_REG-1:0] i_ID_rt;
  logic              i_ID_uses_rt;
  logic              i_ID_halt;
  logic              i_EX_mem_read;
  logic [NB_REG-1:0] i_EX_rt;
  logic              i_MEM_branch_taken;
  logic              i_step_mode;
  logic              i_step;

  logic              o_pipe_enable;
  logic              o_pc_write;
  logic              o_IF_ID_write;
  logic              o_IF_ID_flush;
  logic              o_ID_EX_flush;
  logic              o_EX_MEM_flush;
  logic              o_halted;
  logic [NB_CNT-1:0] o_cycle_count;
  logic [NB_CNT-1:0] o_stall_count;

  modport master (
    output i_ID_rs, i_ID_rt, i_ID_uses_rt, i_ID_halt,
    output i_EX_mem_read, i_EX_rt, i_MEM_branch_taken,
    output i_step_mode, i_step,
    input  o_pipe_enable, o_pc_write, o_IF_ID_write,
    input  o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush,
    input  o_halted, o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_ID_rs, i_ID_rt, i_ID_uses_rt, i_ID_halt,
    input  i_EX_mem_read, i_EX_rt, i_MEM_branch_taken,
    input  i_step_mode, i_step,
    output o_pipe_enable, o_pc_write, o_IF_ID_write,
    output o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush,
    output o_halted, o_cycle_count, o_stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detector.sv
// Combinational load-use comparator: a load in EX whose destination
// is read by the instruction in ID. $0 never creates a hazard.
module load_use_detector
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NB = NB_REG
) (
  input  logic          i_mem_read,
  input  logic [NB-1:0] i_dst,
  input  logic [NB-1:0] i_src_a,
  input  logic [NB-1:0] i_src_b,
  input  logic          i_src_b_used,
  output logic          o_hazard
);

  logic dst_live;
  logic hit_a;
  logic hit_b;

  assign dst_live = i_mem_read & (i_dst != '0);
  assign hit_a    = (i_dst == i_src_a);
  assign hit_b    = i_src_b_used & (i_dst == i_src_b);
  assign o_hazard = dst_live & (hit_a | hit_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: load-use stalls, branch flushes, HALT drain and
// debug single-step. All control outputs are Mealy.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN = DRAIN_CYCLES
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int NB_DRN = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [NB_DRN-1:0] drain;
  logic [NB_DRN-1:0] drain_nxt;
  logic [NB_CNT-1:0] cycle_cnt;
  logic [NB_CNT-1:0] stall_cnt;
  ctrl_t             ctrl;
  logic              stall_inc;
  logic              load_use;
  logic              take_br;
  logic              take_lu;
  logic              take_halt;

  load_use_detector #(
    .NB (NB_REG)
  ) u_lud (
    .i_mem_read   (bus.i_EX_mem_read),
    .i_dst        (bus.i_EX_rt),
    .i_src_a      (bus.i_ID_rs),
    .i_src_b      (bus.i_ID_rt),
    .i_src_b_used (bus.i_ID_uses_rt),
    .o_hazard     (load_use)
  );

  // Priority branch > load-use > halt, made one-hot for the decoder.
  assign take_br   = bus.i_MEM_branch_taken;
  assign take_lu   = load_use & ~take_br;
  assign take_halt = bus.i_ID_halt & ~take_br & ~load_use;

  always_comb begin
    state_nxt = state;
    drain_nxt = drain;
    ctrl      = CTRL_IDLE;
    stall_inc = 1'b0;
    unique case (state)
      ST_RUN, ST_STEP_EXEC: begin
        unique case (1'b1)
          take_br:   ctrl = CTRL_BRANCH;
          take_lu: begin
            ctrl      = CTRL_BUBBLE;
            stall_inc = 1'b1;
          end
          take_halt: ctrl = CTRL_BUBBLE;
          default:   ctrl = CTRL_NORMAL;
        endcase
        if (take_halt) begin
          state_nxt = ST_HALT_DRAIN;
          drain_nxt = NB_DRN'(DRAIN - 1);
        end else if (bus.i_step_mode) begin
          state_nxt = ST_STEP_WAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_STEP_WAIT: begin
        if (bus.i_step_mode && bus.i_step) begin
          state_nxt = ST_STEP_EXEC;
        end else if (!bus.i_step_mode) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT_DRAIN: begin
        // An older branch resolving here makes the HALT wrong-path.
        if (take_br) begin
          ctrl      = CTRL_BRANCH;
          state_nxt = ST_RUN;
        end else begin
          ctrl = CTRL_BUBBLE;
          if (drain == '0) begin
            state_nxt = ST_HALTED;
          end else begin
            drain_nxt = drain - NB_DRN'(1);
          end
        end
      end
      ST_HALTED: begin
        ctrl = CTRL_HALTED;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (!i_reset_n) begin
      ctrl      = CTRL_RESET;
      stall_inc = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state     <= ST_RUN;
      drain     <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      drain <= drain_nxt;
      if (ctrl.pipe_enable) begin
        cycle_cnt <= cycle_cnt + NB_CNT'(1);
      end
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + NB_CNT'(1);
      end
    end
  end

  assign bus.o_pipe_enable  = ctrl.pipe_enable;
  assign bus.o_pc_write     = ctrl.pc_write;
  assign bus.o_IF_ID_write  = ctrl.if_id_write;
  assign bus.o_IF_ID_flush  = ctrl.if_id_flush;
  assign bus.o_ID_EX_flush  = ctrl.id_ex_flush;
  assign bus.o_EX_MEM_flush = ctrl.ex_mem_flush;
  assign bus.o_halted       = ctrl.halted;
  assign bus.o_cycle_count  = cycle_cnt;
  assign bus.o_stall_count  = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle pushes
// its expected controls and counters; the negedge checker pops them.
module tb_pipeline_hazard_ctrl;

  // ctl bits: pe, pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
  //           EX_MEM_flush, halted
  localparam logic [6:0] NRM = 7'b1110000;
  localparam logic [6:0] BUB = 7'b1000100;
  localparam logic [6:0] BRF = 7'b1111110;
  localparam logic [6:0] RST = 7'b1001110;
  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] HLT = 7'b0000001;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   exp_cyc;
  int   exp_stl;
  exp_t sb[$];

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e = sb.pop_front();
      got = {bus.o_pipe_enable, bus.o_pc_write, bus.o_IF_ID_write,
             bus.o_IF_ID_flush, bus.o_ID_EX_flush,
             bus.o_EX_MEM_flush, bus.o_halted};
      check({e.tag, ".ctl"}, 32'(got), 32'(e.ctl));
      check({e.tag, ".cyc"}, bus.o_cycle_count, e.cyc);
      check({e.tag, ".stl"}, bus.o_stall_count, e.stl);
    end
  end

  task automatic cyc(input string tag, input logic rn,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr,
                     input logic [4:0] ert, input logic hlt,
                     input logic br, input logic sm, input logic st,
                     input logic [6:0] ctl, input logic sinc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                  = rn;
    bus.i_ID_rs            = rs;
    bus.i_ID_rt            = rt;
    bus.i_ID_uses_rt       = urt;
    bus.i_EX_mem_read      = mr;
    bus.i_EX_rt            = ert;
    bus.i_ID_halt          = hlt;
    bus.i_MEM_branch_taken = br;
    bus.i_step_mode        = sm;
    bus.i_step             = st;
    e.tag = tag;
    e.ctl = ctl;
    e.cyc = 32'(exp_cyc);
    e.stl = 32'(exp_stl);
    sb.push_back(e);
    if (!rn) begin
      exp_cyc = 0;
      exp_stl = 0;
    end else begin
      exp_cyc += int'(ctl[6]);
      exp_stl += int'(sinc);
    end
  endtask

  // Quiet cycle helper: no hazards, only mode/step/halt/branch vary.
  task automatic q(input string tag, input logic rn, input logic hlt,
                   input logic br, input logic sm, input logic st,
                   input logic [6:0] ctl);
    cyc(tag, rn, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0,
        hlt, br, sm, st, ctl, 1'b0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cyc = 0;
    exp_stl = 0;
    rst_n   = 1'b0;
    bus.i_ID_rs            = '0;
    bus.i_ID_rt            = '0;
    bus.i_ID_uses_rt       = 1'b0;
    bus.i_ID_halt          = 1'b0;
    bus.i_EX_mem_read      = 1'b0;
    bus.i_EX_rt            = '0;
    bus.i_MEM_branch_taken = 1'b0;
    bus.i_step_mode        = 1'b0;
    bus.i_step             = 1'b0;

    q("rst0", 0, 0, 0, 0, 0, RST);
    q("rst1", 0, 0, 0, 0, 0, RST);
    q("run0", 1, 0, 0, 0, 0, NRM);
    q("run1", 1, 0, 0, 0, 0, NRM);

    cyc("lu_rs", 1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 0, 0, 0, 0, BUB, 1);
    q("lu_after", 1, 0, 0, 0, 0, NRM);
    cyc("lw_r0", 1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 0, 0, 0, 0, NRM, 0);
    cyc("rt_unused", 1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5,
        0, 0, 0, 0, NRM, 0);
    cyc("lu_rt", 1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 0, 0, 0, 0, BUB, 1);
    cyc("br_all", 1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1, 1, 0, 0, BRF, 0);
    q("br_after", 1, 0, 0, 0, 0, NRM);

    q("halt_id", 1, 1, 0, 0, 0, BUB);
    q("drain1", 1, 0, 0, 1, 0, BUB);
    q("drain2", 1, 0, 0, 0, 0, BUB);
    q("drain3", 1, 0, 0, 0, 0, BUB);
    q("halted0", 1, 0, 0, 0, 0, HLT);
    q("halted1", 1, 0, 1, 1, 1, HLT);

    q("rst2", 0, 0, 0, 0, 0, RST);
    q("halt_b", 1, 1, 0, 0, 0, BUB);
    q("drain_b1", 1, 0, 0, 0, 0, BUB);
    q("drain_b2", 1, 0, 1, 0, 0, BRF);
    q("brk_run0", 1, 1, 1, 0, 0, BRF);
    q("brk_run1", 1, 0, 0, 0, 0, NRM);

    q("halt_r", 1, 1, 0, 0, 0, BUB);
    q("drain_r1", 1, 0, 0, 0, 0, BUB);
    q("rst_mid0", 0, 0, 0, 0, 0, RST);
    q("rst_mid1", 0, 0, 0, 0, 0, RST);
    q("post_rst", 1, 0, 0, 0, 0, NRM);

    q("sm_enter", 1, 0, 0, 1, 0, NRM);
    q("sw0", 1, 0, 0, 1, 0, IDL);
    q("sw1", 1, 0, 0, 1, 0, IDL);
    for (int p = 0; p < 3; p++) begin
      q($sformatf("pulse%0d", p), 1, 0, 0, 1, 1, IDL);
      q($sformatf("exec%0d", p), 1, 0, 0, 1, 0, NRM);
      for (int w = 0; w < 3; w++)
        q($sformatf("wait%0d_%0d", p, w), 1, 0, 0, 1, 0, IDL);
    end
    q("sm_off", 1, 0, 0, 0, 1, IDL);
    q("sm_run0", 1, 0, 0, 0, 0, NRM);
    cyc("sm_lu", 1, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 0, 0, 0, 0, BUB, 1);
    q("sm_run1", 1, 0, 0, 0, 0, NRM);

    @(negedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
